// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to a PS/2 device: inhibits the clock line, issues
// request-to-send, shifts data/parity/stop on device-generated falling clock
// edges, checks the device ack and waits for both lines to go idle.
//
// Ports:
//   clock       system clock, rising edge
//   nReset      asynchronous active-low reset
//   tx_data     command byte, latched when a request is accepted
//   tx_req      send request, honoured only while ready=1
//   ready       idle and able to accept tx_req
//   done        one-cycle pulse: frame acknowledged and lines idle
//   error       one-cycle pulse: timeout or missing ack
//   ps2_clk_i   PS/2 clock pin level
//   ps2_clk_oe  1 = pull clock line low, 0 = release
//   ps2_dat_i   PS/2 data pin level
//   ps2_dat_oe  1 = pull data line low, 0 = release
//   busy        not idle (lets the receive path ignore this frame)
module ps2_host_tx #(
    parameter logic [15:0] CLK_MHZ    = 16'd50,
    parameter logic [15:0] INHIBIT_US = 16'd100,
    parameter logic [15:0] TIMEOUT_MS = 16'd15
) (
    input  logic       clock,
    input  logic       nReset,
    input  logic [7:0] tx_data,
    input  logic       tx_req,
    output logic       ready,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_i,
    output logic       ps2_clk_oe,
    input  logic       ps2_dat_i,
    output logic       ps2_dat_oe,
    output logic       busy
);

    localparam logic [31:0] INH_CYC  = 32'(INHIBIT_US) * 32'(CLK_MHZ);
    localparam logic [31:0] TO_CYC   = 32'(TIMEOUT_MS) * 32'd1000 * 32'(CLK_MHZ);
    // Terminal counts are one less than the cycle counts because the timer
    // starts at zero on the cycle the state is entered.
    localparam logic [23:0] INH_LAST = 24'(INH_CYC - 32'd1);
    localparam logic [23:0] TO_LAST  = 24'(TO_CYC - 32'd1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        DATA,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t      state, state_n;

    logic        clk_s1, clk_s2;
    logic        dat_s1, dat_s2;
    logic [2:0]  clk_hist;
    logic        clk_filt, clk_filt_d;
    logic        fall;

    logic [23:0] tmr, tmr_n, tmr_inc;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [9:0]  frame, frame_n;
    logic        clk_oe_n, dat_oe_n;
    logic        done_n, error_n;
    logic        ready_n, busy_n;
    logic        timed_out;

    // Pin synchronizers and 4-sample clock glitch filter
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            dat_s1     <= 1'b1;
            dat_s2     <= 1'b1;
            clk_hist   <= '1;
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
        end else begin
            clk_s1     <= ps2_clk_i;
            clk_s2     <= clk_s1;
            dat_s1     <= ps2_dat_i;
            dat_s2     <= dat_s1;
            clk_hist   <= {clk_hist[1:0], clk_s2};
            clk_filt_d <= clk_filt;
            if ({clk_hist, clk_s2} == 4'b0000) begin
                clk_filt <= 1'b0;
            end else if ({clk_hist, clk_s2} == 4'b1111) begin
                clk_filt <= 1'b1;
            end
        end
    end

    assign fall = clk_filt_d & ~clk_filt;

    // State and registered outputs
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            tmr        <= '0;
            bit_cnt    <= '0;
            frame      <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            ready      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            tmr        <= tmr_n;
            bit_cnt    <= bit_cnt_n;
            frame      <= frame_n;
            ps2_clk_oe <= clk_oe_n;
            ps2_dat_oe <= dat_oe_n;
            done       <= done_n;
            error      <= error_n;
            ready      <= ready_n;
            busy       <= busy_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n   = state;
        tmr_n     = tmr;
        bit_cnt_n = bit_cnt;
        frame_n   = frame;
        clk_oe_n  = ps2_clk_oe;
        dat_oe_n  = ps2_dat_oe;
        done_n    = 1'b0;
        error_n   = 1'b0;
        tmr_inc   = (tmr == '1) ? tmr : tmr + 24'd1;
        timed_out = (tmr == TO_LAST);

        case (state)
            IDLE: begin
                clk_oe_n = 1'b0;
                dat_oe_n = 1'b0;
                if (ready && tx_req) begin
                    // Shift order: data LSB first, odd parity, stop bit
                    frame_n   = {1'b1, ~^tx_data, tx_data};
                    tmr_n     = '0;
                    bit_cnt_n = '0;
                    clk_oe_n  = 1'b1;
                    state_n   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (tmr == INH_LAST) begin
                    clk_oe_n = 1'b0;
                    dat_oe_n = 1'b1;
                    tmr_n    = '0;
                    state_n  = RTS;
                end else begin
                    tmr_n = tmr_inc;
                end
            end
            RTS: begin
                tmr_n   = tmr_inc;
                state_n = DATA;
            end
            DATA: begin
                tmr_n = tmr_inc;
                if (fall) begin
                    dat_oe_n  = ~frame[0];
                    frame_n   = {1'b1, frame[9:1]};
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd9) begin
                        state_n = ACK;
                    end
                end
            end
            ACK: begin
                tmr_n = tmr_inc;
                if (fall) begin
                    if (!dat_s2) begin
                        state_n = WAIT_IDLE;
                    end else begin
                        error_n  = 1'b1;
                        clk_oe_n = 1'b0;
                        dat_oe_n = 1'b0;
                        state_n  = IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                tmr_n = tmr_inc;
                if (clk_filt && dat_s2) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                clk_oe_n = 1'b0;
                dat_oe_n = 1'b0;
                state_n  = IDLE;
            end
        endcase

        // Timeout overrides whatever the active state decided this cycle,
        // so done and error can never pulse together.
        if ((state == RTS || state == DATA || state == ACK || state == WAIT_IDLE) && timed_out) begin
            done_n   = 1'b0;
            error_n  = 1'b1;
            clk_oe_n = 1'b0;
            dat_oe_n = 1'b0;
            state_n  = IDLE;
        end

        ready_n = (state_n == IDLE);
        busy_n  = (state_n != IDLE);
    end

endmodule
